// File: rtl/rs485_frame_ctrl.sv
// rs485_frame_ctrl: parses 55 AA CMD ADDR LEN D0..Dn CHK frames from the byte receiver
// and commits checksum-validated payloads to the BRAM write port.
module rs485_frame_ctrl #(
   parameter int ADDR_W = 8,
   parameter int MAX_LEN = 16,
   parameter int TIMEOUT = 4096,
   parameter logic [7:0] SYNC0 = 8'h55,
   parameter logic [7:0] SYNC1 = 8'hAA,
   parameter logic [7:0] CMD_WR = 8'h01
) (
   input  logic              bclk,
   input  logic              reset,
   input  logic              rx_ready,
   input  logic [7:0]        rx_dout,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [7:0]        bram_din,
   output logic              busy,
   output logic              frame_ok,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic [7:0]        frame_cnt
);
   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int PW = $clog2(MAX_LEN);
   typedef enum logic [2:0] {S_HUNT0, S_HUNT1, S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT} state_t;
   state_t state;
   logic rdy_d, strobe, in_frame;
   logic [7:0] sum;
   logic [ADDR_W-1:0] base;
   logic [IW-1:0] len, idx, wr_idx;
   logic [15:0] gap;
   logic [7:0] pay [MAX_LEN];
   assign strobe = rx_ready & ~rdy_d;
   assign in_frame = state inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK};
   assign busy = state != S_HUNT0;
   // payload buffer carries no reset; it is always rewritten before being read
   always_ff @(posedge bclk)
      if (strobe && state == S_DATA) pay[idx[PW-1:0]] <= rx_dout;
   always_ff @(posedge bclk or negedge reset)
      if (!reset) begin
         state <= S_HUNT0;
         rdy_d <= 1'b1;
         sum <= '0;
         base <= '0;
         len <= '0;
         idx <= '0;
         wr_idx <= '0;
         gap <= '0;
         bram_we <= 1'b0;
         bram_addr <= '0;
         bram_din <= '0;
         frame_ok <= 1'b0;
         frame_err <= 1'b0;
         err_code <= 2'd0;
         frame_cnt <= '0;
      end else begin
         rdy_d <= rx_ready;
         frame_ok <= 1'b0;
         frame_err <= 1'b0;
         gap <= (strobe || !in_frame) ? '0 : gap + 16'd1;
         if (state == S_COMMIT) begin
            if (wr_idx < len) begin
               bram_we <= 1'b1;
               bram_addr <= base + ADDR_W'(wr_idx);
               bram_din <= pay[wr_idx[PW-1:0]];
               wr_idx <= wr_idx + 1'b1;
            end else begin
               bram_we <= 1'b0;
               frame_ok <= 1'b1;
               frame_cnt <= frame_cnt + 8'd1;
               state <= S_HUNT0;
            end
         end else if (strobe) begin
            case (state)
               S_HUNT0: state <= (rx_dout == SYNC0) ? S_HUNT1 : S_HUNT0;
               S_HUNT1: state <= (rx_dout == SYNC1) ? S_CMD : (rx_dout == SYNC0) ? S_HUNT1 : S_HUNT0;
               S_CMD:
                  if (rx_dout == CMD_WR) begin
                     sum <= rx_dout;
                     state <= S_ADDR;
                  end else begin
                     frame_err <= 1'b1;
                     err_code <= 2'd2;
                     state <= S_HUNT0;
                  end
               S_ADDR: begin
                  base <= ADDR_W'(rx_dout);
                  sum <= sum + rx_dout;
                  state <= S_LEN;
               end
               S_LEN:
                  if (rx_dout != 8'd0 && rx_dout <= 8'(MAX_LEN)) begin
                     len <= rx_dout[IW-1:0];
                     sum <= sum + rx_dout;
                     idx <= '0;
                     state <= S_DATA;
                  end else begin
                     frame_err <= 1'b1;
                     err_code <= 2'd1;
                     state <= S_HUNT0;
                  end
               S_DATA: begin
                  sum <= sum + rx_dout;
                  idx <= idx + 1'b1;
                  state <= (idx == len - 1'b1) ? S_CHK : S_DATA;
               end
               S_CHK:
                  // first write is issued here so the burst occupies exactly LEN cycles
                  if (rx_dout == sum) begin
                     bram_we <= 1'b1;
                     bram_addr <= base;
                     bram_din <= pay[0];
                     wr_idx <= IW'(1);
                     state <= S_COMMIT;
                  end else begin
                     frame_err <= 1'b1;
                     err_code <= 2'd0;
                     state <= S_HUNT0;
                  end
               default: state <= S_HUNT0;
            endcase
         end else if (in_frame && gap == 16'(TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            err_code <= 2'd3;
            state <= S_HUNT0;
         end
      end
endmodule

// File: tb/tb_rs485_frame_ctrl.sv
// tb_rs485_frame_ctrl: table-driven frame vectors plus directed timeout and reset-in-commit sequences.
module tb_rs485_frame_ctrl;
   logic bclk = 1'b0;
   logic reset = 1'b0;
   logic rx_ready = 1'b1;
   logic [7:0] rx_dout = 8'h00;
   logic bram_we, busy, frame_ok, frame_err;
   logic [7:0] bram_addr, bram_din, frame_cnt;
   logic [1:0] err_code;
   rs485_frame_ctrl dut (
      .bclk(bclk), .reset(reset), .rx_ready(rx_ready), .rx_dout(rx_dout),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .busy(busy),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt)
   );
   always #5 bclk = ~bclk;
   typedef struct {
      logic [95:0] b;
      int n;
      bit ok;
      logic [1:0] code;
      int nwr;
      logic [23:0] wa;
      logic [23:0] wd;
      logic [7:0] cnt;
   } vec_t;
   vec_t vs[$];
   logic [7:0] wa_q[$], wd_q[$];
   int ok_n = 0, err_n = 0, pass_n = 0, tot_n = 0;
   always @(negedge bclk) begin
      if (bram_we) begin
         wa_q.push_back(bram_addr);
         wd_q.push_back(bram_din);
      end
      if (frame_ok) ok_n++;
      if (frame_err) err_n++;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic send_byte(input logic [7:0] b);
      @(negedge bclk) rx_ready = 1'b0;
      repeat (2) @(negedge bclk);
      rx_dout = b;
      rx_ready = 1'b1;
      @(negedge bclk);
   endtask
   task automatic add(input logic [95:0] b, input int n, input bit ok, input logic [1:0] code,
                      input int nwr, input logic [23:0] wa, input logic [23:0] wd, input logic [7:0] cnt);
      vec_t v;
      v.b = b; v.n = n; v.ok = ok; v.code = code; v.nwr = nwr; v.wa = wa; v.wd = wd; v.cnt = cnt;
      vs.push_back(v);
   endtask
   task automatic run_vec(input vec_t v, input string tag);
      int ok0, err0;
      wa_q.delete();
      wd_q.delete();
      ok0 = ok_n;
      err0 = err_n;
      for (int i = 0; i < v.n; i++) send_byte(v.b[95-8*i -: 8]);
      repeat (25) @(negedge bclk);
      chk({tag, " frame_ok pulses"}, ok_n - ok0, v.ok ? 1 : 0);
      chk({tag, " frame_err pulses"}, err_n - err0, v.ok ? 0 : 1);
      if (!v.ok) chk({tag, " err_code"}, err_code, v.code);
      chk({tag, " write count"}, wa_q.size(), v.nwr);
      for (int j = 0; j < v.nwr && j < wa_q.size(); j++) begin
         chk({tag, " write addr"}, wa_q[j], v.wa[23-8*j -: 8]);
         chk({tag, " write data"}, wd_q[j], v.wd[23-8*j -: 8]);
      end
      chk({tag, " frame_cnt"}, frame_cnt, v.cnt);
      chk({tag, " busy idle"}, busy, 0);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int w;
      vec_t good;
      add({72'h55AA0110031122337B, 24'h0}, 9, 0, 2'd0, 0, 24'h0, 24'h0, 8'd0);
      add({40'h55AA010000, 56'h0}, 5, 0, 2'd1, 0, 24'h0, 24'h0, 8'd0);
      add({40'h55AA010011, 56'h0}, 5, 0, 2'd1, 0, 24'h0, 24'h0, 8'd0);
      add({24'h55AA02, 72'h0}, 3, 0, 2'd2, 0, 24'h0, 24'h0, 8'd0);
      add({72'h55AA0110031122337B, 24'h0}, 9, 0, 2'd0, 0, 24'h0, 24'h0, 8'd0);
      add({72'h55AA0110031122337A, 24'h0}, 9, 1, 2'd0, 3, 24'h101112, 24'h112233, 8'd1);
      add({80'h5555AA01FE0301020308, 16'h0}, 10, 1, 2'd0, 3, 24'hFEFF00, 24'h010203, 8'd2);
      good = vs[5];
      repeat (3) @(negedge bclk);
      chk("reset bram_we", bram_we, 0);
      chk("reset busy", busy, 0);
      chk("reset frame_cnt", frame_cnt, 0);
      chk("reset err_code", err_code, 0);
      reset = 1'b1;
      repeat (3) @(negedge bclk);
      chk("idle after reset", {frame_ok, frame_err, busy}, 0);
      for (int k = 0; k < vs.size(); k++) run_vec(vs[k], $sformatf("vec%0d", k));
      // stall mid-header until the inter-byte timeout fires
      err_n = 0;
      send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10);
      chk("timeout busy", busy, 1);
      w = 0;
      for (int i = 1; i <= 5000; i++) begin
         @(negedge bclk);
         if (frame_err) begin
            w = i;
            break;
         end
      end
      chk("timeout latency", w, 4096);
      chk("timeout err_code", err_code, 3);
      repeat (2) @(negedge bclk);
      chk("timeout busy cleared", busy, 0);
      good.cnt = 8'd3;
      run_vec(good, "post-timeout");
      // reset during the second COMMIT write
      for (int i = 0; i < 9; i++) send_byte(good.b[95-8*i -: 8]);
      chk("commit first we", bram_we, 1);
      @(negedge bclk);
      chk("commit second addr", {bram_we, bram_addr}, {1'b1, 8'h11});
      ok_n = 0;
      err_n = 0;
      reset = 1'b0;
      #1;
      chk("mid-commit reset we", bram_we, 0);
      chk("mid-commit reset addr/din", {bram_addr, bram_din}, 0);
      chk("mid-commit reset flags", {busy, frame_ok, frame_err, err_code}, 0);
      chk("mid-commit reset cnt", frame_cnt, 0);
      repeat (3) @(negedge bclk);
      reset = 1'b1;
      repeat (3) @(negedge bclk);
      chk("no pulse after reset", ok_n + err_n, 0);
      good.cnt = 8'd1;
      run_vec(good, "post-reset");
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
